// File: rtl/except_arbiter_nway_if.sv
// Lane, CP0 and request bundle between the writeback stage (master) and the
// exception arbiter (slave).
interface except_arbiter_nway_if #(
  parameter int LANES = 2,
  parameter int IRQ_W = 8
);
  logic [LANES-1:0]    lane_valid;
  logic [32*LANES-1:0] lane_pc;
  logic [LANES-1:0]    lane_delayslot;
  logic [14*LANES-1:0] lane_exc;
  logic [LANES-1:0]    lane_mem_we;
  logic [32*LANES-1:0] lane_vaddr;
  logic                user_mode;
  logic                st_ie;
  logic                st_exl;
  logic                st_erl;
  logic                st_bev;
  logic                cause_iv;
  logic [31:0]         epc;
  logic [31:0]         error_epc;
  logic [IRQ_W-1:0]    irq_raw;

  logic                accept;
  logic                flush;
  logic [4:0]          code;
  logic                eret;
  logic [31:0]         cur_pc;
  logic                delayslot;
  logic [31:0]         jump_pc;
  logic [31:0]         extra;
  logic [LANES-1:0]    kill;

  modport master (
    output lane_valid, lane_pc, lane_delayslot, lane_exc, lane_mem_we, lane_vaddr,
           user_mode, st_ie, st_exl, st_erl, st_bev, cause_iv, epc, error_epc, irq_raw,
    input  accept, flush, code, eret, cur_pc, delayslot, jump_pc, extra, kill
  );

  modport slave (
    input  lane_valid, lane_pc, lane_delayslot, lane_exc, lane_mem_we, lane_vaddr,
           user_mode, st_ie, st_exl, st_erl, st_bev, cause_iv, epc, error_epc, irq_raw,
    output accept, flush, code, eret, cur_pc, delayslot, jump_pc, extra, kill
  );
endinterface

// File: rtl/except_arbiter_nway.sv
// Registered N-lane exception arbiter: picks the oldest faulting lane or a
// synchronised interrupt, issues one request, then holds off while the pipe drains.
module except_arbiter_nway #(
  parameter int          LANES        = 2,
  parameter int          IRQ_W        = 8,
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] VEC_BOOT     = 32'hbfc00200,
  parameter logic [31:0] VEC_NORM     = 32'h80000000
) (
  input logic            clk,
  input logic            rst,
  except_arbiter_nway_if.slave bus
);
  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IRQ_W-1:0] irq_meta_q, irq_sync_q;
  logic             flush_q, flush_d;
  logic             eret_q, eret_d;
  logic             ds_q, ds_d;
  logic [4:0]       code_q, code_d;
  logic [31:0]      cur_pc_q, cur_pc_d;
  logic [31:0]      jump_q, jump_d;
  logic [31:0]      extra_q, extra_d;
  logic [LANES-1:0] kill_q, kill_d;

  logic             irq_pend;
  logic             valid_found, fault_found, take;
  logic [13:0]      eff, win_flags;
  logic [31:0]      base;
  int               oldest, win_lane, win_bit, sel;

  assign irq_pend = (|irq_sync_q) & bus.st_ie & ~bus.st_exl & ~bus.st_erl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      irq_meta_q <= '0;
      irq_sync_q <= '0;
      flush_q    <= 1'b0;
      eret_q     <= 1'b0;
      ds_q       <= 1'b0;
      code_q     <= '0;
      cur_pc_q   <= '0;
      jump_q     <= '0;
      extra_q    <= '0;
      kill_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      irq_meta_q <= bus.irq_raw;
      irq_sync_q <= irq_meta_q;
      flush_q    <= flush_d;
      eret_q     <= eret_d;
      ds_q       <= ds_d;
      code_q     <= code_d;
      cur_pc_q   <= cur_pc_d;
      jump_q     <= jump_d;
      extra_q    <= extra_d;
      kill_q     <= kill_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    flush_d     = 1'b0;
    eret_d      = eret_q;
    ds_d        = ds_q;
    code_d      = code_q;
    cur_pc_d    = cur_pc_q;
    jump_d      = jump_q;
    extra_d     = extra_q;
    kill_d      = kill_q;
    valid_found = 1'b0;
    fault_found = 1'b0;
    oldest      = 0;
    win_lane    = 0;
    win_bit     = 0;
    win_flags   = '0;
    eff         = '0;

    // Lane 0 is oldest, so the first hit in ascending order wins.
    for (int k = 0; k < LANES; k++) begin
      eff    = bus.lane_exc[14*k +: 14];
      eff[8] = eff[8] & bus.user_mode;
      if (bus.lane_valid[k] && !valid_found) begin
        valid_found = 1'b1;
        oldest      = k;
      end
      if (bus.lane_valid[k] && (|eff) && !fault_found) begin
        fault_found = 1'b1;
        win_lane    = k;
        win_flags   = eff;
      end
    end
    for (int b = 13; b >= 0; b--) begin
      if (win_flags[b]) win_bit = b;
    end

    sel  = irq_pend ? oldest : win_lane;
    take = (state_q == IDLE) && valid_found && (irq_pend || fault_found);
    base = bus.st_bev ? VEC_BOOT : VEC_NORM;

    case (state_q)
      IDLE: begin
        if (take) begin
          state_d  = HOLD;
          cnt_d    = CNT_W'(FLUSH_CYCLES);
          flush_d  = 1'b1;
          cur_pc_d = bus.lane_pc[32*sel +: 32];
          ds_d     = bus.lane_delayslot[sel];
          for (int k = 0; k < LANES; k++) kill_d[k] = (k >= sel);
          eret_d   = 1'b0;
          extra_d  = '0;
          jump_d   = base + 32'h180;
          if (irq_pend) begin
            code_d               = 5'd0;
            extra_d[IRQ_W-1:0]   = irq_sync_q;
            if (bus.cause_iv && !bus.st_exl) jump_d = base + 32'h200;
          end else begin
            case (win_bit)
              0:       begin code_d = 5'd4; extra_d = cur_pc_d; end
              1, 2:    begin code_d = 5'd2; extra_d = cur_pc_d; end
              3:       code_d = 5'd8;
              4:       code_d = 5'd9;
              5:       code_d = 5'd12;
              6:       code_d = 5'd13;
              7: begin
                code_d = 5'd0;
                eret_d = 1'b1;
                jump_d = bus.st_erl ? bus.error_epc : bus.epc;
              end
              8:       begin code_d = 5'd11; extra_d = 32'd1; end
              9:       code_d = 5'd10;
              10: begin
                code_d  = bus.lane_mem_we[sel] ? 5'd5 : 5'd4;
                extra_d = bus.lane_vaddr[32*sel +: 32];
              end
              11, 12: begin
                code_d  = bus.lane_mem_we[sel] ? 5'd3 : 5'd2;
                extra_d = bus.lane_vaddr[32*sel +: 32];
              end
              default: begin
                code_d  = 5'd1;
                extra_d = bus.lane_vaddr[32*sel +: 32];
              end
            endcase
            // TLB refill goes to the base itself unless already in an exception.
            if ((win_bit == 1 || win_bit == 11) && !bus.st_exl) jump_d = base;
          end
        end
      end
      HOLD: begin
        if (cnt_q == CNT_W'(1)) state_d = IDLE;
        else                    cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.accept    = (state_q == IDLE);
    bus.flush     = flush_q;
    bus.code      = code_q;
    bus.eret      = eret_q;
    bus.cur_pc    = cur_pc_q;
    bus.delayslot = ds_q;
    bus.jump_pc   = jump_q;
    bus.extra     = extra_q;
    bus.kill      = kill_q;
  end
endmodule

// File: tb/tb_except_arbiter_nway.sv
// Directed bench for except_arbiter_nway (LANES=2, IRQ_W=8, FLUSH_CYCLES=2).
module tb_except_arbiter_nway;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  except_arbiter_nway_if #(.LANES(2), .IRQ_W(8)) bus ();

  except_arbiter_nway #(
    .LANES(2), .IRQ_W(8), .FLUSH_CYCLES(2),
    .VEC_BOOT(32'hbfc00200), .VEC_NORM(32'h80000000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_lanes();
    bus.lane_valid     = '0;
    bus.lane_exc       = '0;
    bus.lane_mem_we    = '0;
    bus.lane_delayslot = '0;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, ".accept"}, 32'(bus.accept), 32'd1);
    chk({tag, ".flush"},  32'(bus.flush),  32'd0);
    chk({tag, ".code"},   32'(bus.code),   32'd0);
    chk({tag, ".eret"},   32'(bus.eret),   32'd0);
    chk({tag, ".cur_pc"}, bus.cur_pc,      32'd0);
    chk({tag, ".jump"},   bus.jump_pc,     32'd0);
    chk({tag, ".extra"},  bus.extra,       32'd0);
    chk({tag, ".kill"},   32'(bus.kill),   32'd0);
  endtask

  initial begin
    rst = 1'b1;
    idle_lanes();
    bus.lane_pc    = '0;
    bus.lane_vaddr = '0;
    bus.user_mode  = 1'b0;
    bus.st_ie      = 1'b0;
    bus.st_exl     = 1'b0;
    bus.st_erl     = 1'b0;
    bus.st_bev     = 1'b0;
    bus.cause_iv   = 1'b0;
    bus.epc        = 32'h80004000;
    bus.error_epc  = 32'h0;
    bus.irq_raw    = '0;
    tick();
    tick();
    chk_cleared("reset");
    rst = 1'b0;

    // lane1 overflow; lane0 has a flag but is not valid
    bus.lane_valid     = 2'b10;
    bus.lane_exc       = {14'h0020, 14'h0001};
    bus.lane_pc        = {32'h80001004, 32'h80000ff0};
    bus.lane_delayslot = 2'b10;
    tick();
    chk("ov.flush",  32'(bus.flush),  32'd1);
    chk("ov.code",   32'(bus.code),   32'd12);
    chk("ov.cur_pc", bus.cur_pc,      32'h80001004);
    chk("ov.kill",   32'(bus.kill),   32'd2);
    chk("ov.jump",   bus.jump_pc,     32'h80000180);
    chk("ov.extra",  bus.extra,       32'd0);
    chk("ov.ds",     32'(bus.delayslot), 32'd1);
    chk("ov.accept", 32'(bus.accept), 32'd0);
    idle_lanes();
    tick();
    chk("ov.flush_t2",  32'(bus.flush),  32'd0);
    chk("ov.accept_t2", 32'(bus.accept), 32'd0);
    chk("ov.code_hold", 32'(bus.code),   32'd12);
    tick();
    chk("ov.accept_t3", 32'(bus.accept), 32'd1);

    // lane0 store TLB refill beats lane1 syscall
    bus.lane_valid  = 2'b11;
    bus.lane_exc    = {14'h0008, 14'h0800};
    bus.lane_mem_we = 2'b01;
    bus.lane_vaddr  = {32'h0, 32'h00400010};
    bus.lane_pc     = {32'h80001104, 32'h80001100};
    tick();
    chk("tlbs.code",   32'(bus.code), 32'd3);
    chk("tlbs.extra",  bus.extra,     32'h00400010);
    chk("tlbs.jump",   bus.jump_pc,   32'h80000000);
    chk("tlbs.kill",   32'(bus.kill), 32'd3);
    chk("tlbs.cur_pc", bus.cur_pc,    32'h80001100);
    idle_lanes();
    tick();
    tick();

    // priv flag in kernel mode is not a fault; lane1 RI wins
    bus.lane_valid = 2'b11;
    bus.lane_exc   = {14'h0200, 14'h0100};
    tick();
    chk("ri.code",   32'(bus.code), 32'd10);
    chk("ri.kill",   32'(bus.kill), 32'd2);
    chk("ri.cur_pc", bus.cur_pc,    32'h80001104);
    chk("ri.jump",   bus.jump_pc,   32'h80000180);
    idle_lanes();
    tick();
    tick();

    // ERET with erl=1 returns through ErrorEPC
    bus.lane_valid = 2'b01;
    bus.lane_exc   = {14'h0, 14'h0080};
    bus.st_erl     = 1'b1;
    bus.error_epc  = 32'hbfc00380;
    tick();
    chk("eret.eret", 32'(bus.eret), 32'd1);
    chk("eret.code", 32'(bus.code), 32'd0);
    chk("eret.jump", bus.jump_pc,   32'hbfc00380);
    chk("eret.kill", 32'(bus.kill), 32'd3);
    idle_lanes();
    bus.st_erl = 1'b0;
    tick();
    tick();

    // interrupt with cause_iv: three-edge latency
    bus.irq_raw    = 8'h04;
    bus.st_ie      = 1'b1;
    bus.cause_iv   = 1'b1;
    bus.lane_valid = 2'b01;
    bus.lane_pc    = {32'h80002004, 32'h80002000};
    tick();
    chk("int.flush_c1", 32'(bus.flush), 32'd0);
    tick();
    chk("int.flush_c2", 32'(bus.flush), 32'd0);
    tick();
    chk("int.flush",  32'(bus.flush), 32'd1);
    chk("int.code",   32'(bus.code),  32'd0);
    chk("int.extra",  bus.extra,      32'h4);
    chk("int.jump",   bus.jump_pc,    32'h80000200);
    chk("int.cur_pc", bus.cur_pc,     32'h80002000);
    chk("int.eret",   32'(bus.eret),  32'd0);
    chk("int.kill",   32'(bus.kill),  32'd3);
    bus.irq_raw = '0;
    idle_lanes();
    tick();
    tick();
    chk("int.accept_back", 32'(bus.accept), 32'd1);

    // same interrupt with exl=1 is masked
    bus.st_exl     = 1'b1;
    bus.irq_raw    = 8'h04;
    bus.lane_valid = 2'b01;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("int_exl.flush", 32'(bus.flush), 32'd0);
    end
    bus.irq_raw = '0;
    idle_lanes();
    tick();
    tick();
    tick();
    bus.st_exl   = 1'b0;
    bus.cause_iv = 1'b0;

    // interrupt with no valid lane waits, then beats a lane1 fault
    bus.irq_raw = 8'h01;
    for (int i = 0; i < 4; i++) tick();
    chk("defer.flush", 32'(bus.flush), 32'd0);
    bus.lane_valid = 2'b11;
    bus.lane_exc   = {14'h0020, 14'h0};
    bus.lane_pc    = {32'h80003004, 32'h80003000};
    tick();
    chk("defer.flush_go", 32'(bus.flush), 32'd1);
    chk("defer.code",     32'(bus.code),  32'd0);
    chk("defer.extra",    bus.extra,      32'h1);
    chk("defer.kill",     32'(bus.kill),  32'd3);
    chk("defer.cur_pc",   bus.cur_pc,     32'h80003000);
    chk("defer.jump",     bus.jump_pc,    32'h80000180);
    bus.irq_raw = '0;
    bus.st_ie   = 1'b0;
    idle_lanes();
    tick();
    tick();
    chk("defer.accept_back", 32'(bus.accept), 32'd1);

    // back-to-back: second fault ignored during hold-off, taken at t+3
    bus.lane_valid = 2'b01;
    bus.lane_exc   = {14'h0, 14'h0020};
    bus.lane_pc    = {32'h80005004, 32'h80005000};
    tick();
    chk("b2b.flush1", 32'(bus.flush), 32'd1);
    chk("b2b.code1",  32'(bus.code),  32'd12);
    bus.lane_exc = {14'h0, 14'h0008};
    bus.lane_pc  = {32'h80005014, 32'h80005010};
    tick();
    chk("b2b.flush_t2",  32'(bus.flush),  32'd0);
    chk("b2b.accept_t2", 32'(bus.accept), 32'd0);
    tick();
    chk("b2b.flush_t3",  32'(bus.flush),  32'd0);
    chk("b2b.accept_t3", 32'(bus.accept), 32'd1);
    chk("b2b.code_hold", 32'(bus.code),   32'd12);
    chk("b2b.pc_hold",   bus.cur_pc,      32'h80005000);
    tick();
    chk("b2b.flush2", 32'(bus.flush), 32'd1);
    chk("b2b.code2",  32'(bus.code),  32'd8);
    chk("b2b.pc2",    bus.cur_pc,     32'h80005010);

    // reset while holding off, then a normal fault with bev=1
    rst = 1'b1;
    tick();
    chk_cleared("rst_hold");
    rst = 1'b0;
    bus.lane_valid = 2'b11;
    bus.lane_exc   = {14'h0040, 14'h0};
    bus.lane_pc    = {32'h80006004, 32'h80006000};
    bus.st_bev     = 1'b1;
    tick();
    chk("tr.flush",  32'(bus.flush), 32'd1);
    chk("tr.code",   32'(bus.code),  32'd13);
    chk("tr.kill",   32'(bus.kill),  32'd2);
    chk("tr.cur_pc", bus.cur_pc,     32'h80006004);
    chk("tr.jump",   bus.jump_pc,    32'hbfc00380);
    idle_lanes();
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
